conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Upstream neighbour of the 3x3 convolution layer: converts a raster-order pixel stream into 3x3 sliding windows for the convolution layer's `in` bus and `de` strobe. It holds two full image rows in line buffers plus a 3x3 register window. It emits one window per accepted pixel once the window is fully inside the image, giving a "valid" convolution of (IMG_H-2) x (IMG_W-2) outputs per frame.

## Interface
- `bit_depth`, 16, pixel width in bits.
- `IMG_W`, 28, pixels per row; legal range 3..1023.
- `IMG_H`, 28, rows per frame; legal range 3..1023.

Ports:
- `clk`  input  1  the single clock; all state changes on the rising edge.
- `RESET`  input  1  asynchronous, active-low reset.
- `sof`  input  1  start of frame; qualified by `in_valid`.
- `in_valid`  input  1  `pix_in` is valid this cycle.
- `pix_in`  input  bit_depth  pixel, raster order (row-major, left to right).
- `de`  output  1  `win` holds a valid window this cycle.
- `win`  output  bit_depth*9  3x3 window, packed MSB-first:
  - `[bd*9-1:bd*8]` = top-left (row r-2, col c-2).
  - ... row-major ...
  - `[bd-1:0]` = bottom-right (row r, col c).
  - bd = bit_depth.
- `frame_done`  output  1  one-cycle pulse with the last window of a frame.

## Operation
- Counters:
  - `col` counts 0..IMG_W-1 and `row` counts 0..IMG_H-1, both 10 bits.
  - They give the position of the next pixel to be accepted.
  - They advance only on cycles where `in_valid`=1.
  - At `col`=IMG_W-1, `col` wraps to 0 and `row` increments.
  - At `row`=IMG_H-1 and `col`=IMG_W-1, both wrap to 0.
- `sof`:
  - When `in_valid`=1 and `sof`=1, the pixel is treated as (0,0) regardless of the counters. Counters then become (0,1).
  - `sof` is ignored when `in_valid`=0.
- Line buffers: two arrays `lb0` and `lb1`, each IMG_W x bit_depth. Register or inferred RAM are both allowed; read-before-write semantics are required. On each accepted pixel at column c:
  - read `t1 = lb1[c]` (row r-2) and `t0 = lb0[c]` (row r-1);
  - write `lb1[c] <= lb0[c]` and `lb0[c] <= pix_in`.
- Window registers (9 x bit_depth). On each accepted pixel:
  - each row shifts one place left;
  - the new right column is {`t1`, `t0`, `pix_in`} (top, middle, bottom).
- Output qualification:
  - `de` is registered: `de` <= `in_valid` && `row`>=2 && `col`>=2, evaluated at the accepted pixel's position.
  - Windows at col<2 or row<2 contain stale data. They are masked by `de`=0 and are not required to be zero.
- Frame end: `frame_done` <= `in_valid` && (`row`,`col`) = (IMG_H-1, IMG_W-1).
- No backpressure. The consumer must take every `de` cycle.
- Line buffer contents are never cleared. The masking rule makes this harmless.

## Timing
- Latency: 1 cycle. The pixel accepted at edge k produces `win`/`de` valid after edge k, held until edge k+1.
- `de` and `frame_done` are single-cycle per accepted pixel.
- With `in_valid` low, `win` holds its value and `de`=0.
- Gaps of any length in `in_valid` are allowed, including mid-row and between frames. Gaps do not affect the window contents.
- Back-to-back frames with no idle cycle are supported. The first pixel of frame N+1 may follow the last pixel of frame N directly, with or without `sof`.
- Reset values: `de`=0, `frame_done`=0, `win`=0, `row`=0, `col`=0.
- Reset mid-frame: outputs clear immediately (asynchronous). The next accepted pixel is (0,0).
- Throughput: 1 pixel per clock sustained. Windows per frame = (IMG_H-2)*(IMG_W-2).

## Test plan
Use IMG_W=5, IMG_H=4, bit_depth=16, pixel value = r*5+c.

- Continuous frame of 20 pixels:
  - exactly 6 `de` pulses;
  - first window = {0,1,2,5,6,7,10,11,12}, appearing the cycle after pixel 12;
  - last window = {7,8,9,12,13,14,17,18,19};
  - `frame_done`=1 only with the last window.
- Same frame with `in_valid` deasserted for 3 cycles after every pixel: identical window sequence, with `de` 1 cycle after each qualifying pixel.
- Two back-to-back frames (second frame pixel values +100): 12 windows total; second-frame first window = {100,101,102,105,106,107,110,111,112}.
- Assert `sof` with pixel 7 mid-frame:
  - no `de` for the next 12 pixels;
  - then the correct window built from the restarted stream.
- Assert `RESET` low after pixel 13, then release:
  - `de`/`win`/`frame_done` go 0 immediately;
  - a fresh 20-pixel frame yields the same 6 windows as the first scenario.
- Random `in_valid` (50%) over 10 frames, checked against a reference model: every window matches, and `de` count = 60.

Source files
------------

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to 3x3 sliding windows.
// Two row line buffers feed a 3x3 shift window; de marks interior windows.
module conv_window_gen #(
  parameter int bit_depth = 16,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   sof,
  input  logic                   in_valid,
  input  logic [bit_depth-1:0]   pix_in,
  output logic                   de,
  output logic [bit_depth*9-1:0] win,
  output logic                   frame_done
);

  localparam int BD = bit_depth;
  localparam int CW = $clog2(IMG_W);
  localparam logic [9:0] LAST_C = 10'(IMG_W - 1);
  localparam logic [9:0] LAST_R = 10'(IMG_H - 1);

  logic [9:0]    col_q, col_d;
  logic [9:0]    row_q, row_d;
  logic [9:0]    cur_col, cur_row;
  logic [CW-1:0] lb_idx;
  logic [BD-1:0] t0, t1;
  logic [BD-1:0] lb0_q [IMG_W];
  logic [BD-1:0] lb1_q [IMG_W];
  logic [BD-1:0] w_q [9];
  logic [BD-1:0] w_d [9];
  logic          de_q, de_d;
  logic          fd_q, fd_d;

  // Position of the pixel being accepted; sof forces (0,0)
  always_comb begin
    cur_col = sof ? 10'd0 : col_q;
    cur_row = sof ? 10'd0 : row_q;
    lb_idx  = cur_col[CW-1:0];
    t0      = lb0_q[lb_idx];
    t1      = lb1_q[lb_idx];
  end

  // Next raster position and output qualifiers
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    de_d  = 1'b0;
    fd_d  = 1'b0;
    if (in_valid) begin
      if (cur_col == LAST_C) begin
        col_d = 10'd0;
        row_d = (cur_row == LAST_R) ? 10'd0 : cur_row + 10'd1;
      end else begin
        col_d = cur_col + 10'd1;
        row_d = cur_row;
      end
      de_d = (cur_row >= 10'd2) && (cur_col >= 10'd2);
      fd_d = (cur_row == LAST_R) && (cur_col == LAST_C);
    end
  end

  // Window shift: rows move left, new right column from buffers + input
  always_comb begin
    w_d = w_q;
    if (in_valid) begin
      w_d[8] = w_q[7];
      w_d[7] = w_q[6];
      w_d[6] = t1;
      w_d[5] = w_q[4];
      w_d[4] = w_q[3];
      w_d[3] = t0;
      w_d[2] = w_q[1];
      w_d[1] = w_q[0];
      w_d[0] = pix_in;
    end
  end

  // Line buffers, read-before-write, never cleared
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1_q[lb_idx] <= lb0_q[lb_idx];
      lb0_q[lb_idx] <= pix_in;
    end
  end

  // Counters, window and strobes
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      col_q <= 10'd0;
      row_q <= 10'd0;
      de_q  <= 1'b0;
      fd_q  <= 1'b0;
      for (int i = 0; i < 9; i++) w_q[i] <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      de_q  <= de_d;
      fd_q  <= fd_d;
      w_q   <= w_d;
    end
  end

  // Pack window, top-left in the MSBs
  always_comb begin
    win = '0;
    for (int i = 0; i < 9; i++) win[BD*i +: BD] = w_q[i];
  end

  assign de         = de_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed checks of conv_window_gen at 5x4, 16 bit.
// Expected windows come from a position-indexed image model.
module tb_conv_window_gen;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int BD = 16;

  logic            clk;
  logic            RESET;
  logic            sof;
  logic            in_valid;
  logic [BD-1:0]   pix_in;
  logic            de;
  logic [BD*9-1:0] win;
  logic            frame_done;

  conv_window_gen #(
    .bit_depth(BD),
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clk(clk),
    .RESET(RESET),
    .sof(sof),
    .in_valid(in_valid),
    .pix_in(pix_in),
    .de(de),
    .win(win),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int de_cnt = 0;
  int mr = 0;
  int mc = 0;
  logic [BD-1:0]   img [H][W];
  logic [BD*9-1:0] exp_win = '0;
  bit              win_known = 1'b1;

  task automatic check(input string tag,
                       input logic [143:0] obs,
                       input logic [143:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] p9(input int a, b, c, d, e,
                                      f, g, h, i);
    return {16'(a), 16'(b), 16'(c), 16'(d), 16'(e),
            16'(f), 16'(g), 16'(h), 16'(i)};
  endfunction

  function automatic logic [143:0] win_at(input int r, input int c);
    return {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
            img[r-1][c-2], img[r-1][c-1], img[r-1][c],
            img[r][c-2],   img[r][c-1],   img[r][c]};
  endfunction

  task automatic step(input bit v, input bit s, input int px);
    bit e_de;
    bit e_fd;
    int pr;
    int pc;
    @(negedge clk);
    in_valid = v;
    sof      = s;
    pix_in   = BD'(px);
    e_de = 1'b0;
    e_fd = 1'b0;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      pr = mr;
      pc = mc;
      img[pr][pc] = BD'(px);
      e_de = (pr >= 2) && (pc >= 2);
      e_fd = (pr == H-1) && (pc == W-1);
      if (e_de) begin
        exp_win   = win_at(pr, pc);
        win_known = 1'b1;
      end else begin
        win_known = 1'b0;
      end
      if (mc == W-1) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    @(posedge clk);
    #1;
    check("de", 144'(de), 144'(e_de));
    check("frame_done", 144'(frame_done), 144'(e_fd));
    if (win_known) check("win", win, exp_win);
    if (de) de_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RESET    = 1'b0;
    sof      = 1'b0;
    in_valid = 1'b0;
    pix_in   = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_de", 144'(de), 144'(0));
    check("rst_fd", 144'(frame_done), 144'(0));
    check("rst_win", win, 144'(0));
    @(negedge clk);
    RESET = 1'b1;

    // continuous frame
    de_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, i == 0, i);
      if (i == 12)
        check("s1_first", win, p9(0, 1, 2, 5, 6, 7, 10, 11, 12));
      if (i == 19)
        check("s1_last", win, p9(7, 8, 9, 12, 13, 14, 17, 18, 19));
    end
    check("s1_count", 144'(de_cnt), 144'(6));

    // three idle cycles after each pixel
    de_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, i == 0, i);
      if (i == 12)
        check("s2_first", win, p9(0, 1, 2, 5, 6, 7, 10, 11, 12));
      repeat (3) step(0, 0, 0);
      if (i == 19)
        check("s2_last_hold", win, p9(7, 8, 9, 12, 13, 14, 17, 18, 19));
    end
    check("s2_count", 144'(de_cnt), 144'(6));

    // back-to-back frames, second offset by 100
    de_cnt = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 20; i++) begin
        step(1, (i == 0) && (f == 1), f*100 + i);
        if (f == 1 && i == 12)
          check("s3_f2_first", win,
                p9(100, 101, 102, 105, 106, 107, 110, 111, 112));
      end
    check("s3_count", 144'(de_cnt), 144'(12));

    // sof restart at pixel 7
    de_cnt = 0;
    for (int i = 0; i < 7; i++) step(1, i == 0, i);
    step(1, 1, 0);
    for (int i = 1; i < 20; i++) begin
      step(1, 0, i);
      if (i == 11) check("s4_no_de", 144'(de_cnt), 144'(0));
      if (i == 12)
        check("s4_first", win, p9(0, 1, 2, 5, 6, 7, 10, 11, 12));
    end
    check("s4_count", 144'(de_cnt), 144'(6));

    // asynchronous reset after pixel 13
    for (int i = 0; i < 14; i++) step(1, i == 0, i);
    check("s5_pre_de", 144'(de), 144'(1));
    #2;
    RESET    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("s5_rst_de", 144'(de), 144'(0));
    check("s5_rst_win", win, 144'(0));
    check("s5_rst_fd", 144'(frame_done), 144'(0));
    mr = 0;
    mc = 0;
    exp_win   = '0;
    win_known = 1'b1;
    @(negedge clk);
    RESET = 1'b1;
    de_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, i);
      if (i == 12)
        check("s5_first", win, p9(0, 1, 2, 5, 6, 7, 10, 11, 12));
      if (i == 19)
        check("s5_last", win, p9(7, 8, 9, 12, 13, 14, 17, 18, 19));
    end
    check("s5_count", 144'(de_cnt), 144'(6));

    // random in_valid over ten frames
    de_cnt = 0;
    for (int f = 0; f < 10; f++)
      for (int i = 0; i < 20; i++) begin
        while (($urandom & 1) == 0) step(0, 0, 0);
        step(1, (i == 0) && (f % 2 == 0), f*100 + i);
      end
    check("s6_count", 144'(de_cnt), 144'(60));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
